// File: rtl/ds_serializer.sv
// Two independent word-to-beat serializers (gray: address, lbp: address+data) feeding narrow pad ports.
// Each channel accepts a padded word, then streams it out one slice per ser_en-qualified cycle.

module ds_ser_chan #(
  parameter int BEATS     = 4,
  parameter int SW        = 4,
  parameter bit MSB_FIRST = 1'b1,
  localparam int W        = BEATS * SW,
  localparam int CNT_W    = $clog2(BEATS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ser_en,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_word,
  output logic [SW-1:0]    slice,
  output logic             valid,
  output logic             first,
  output logic             last,
  output logic [CNT_W-1:0] count,
  output logic             busy
);
  // Handshake: a word transfers on a rising edge where in_valid & in_ready are both 1;
  // the producer holds in_valid and the word stable until then. in_ready never depends on in_valid.
  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_n;
  logic [W-1:0]     sreg, sreg_n, shifted;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             at_last;

  assign at_last = (cnt == CNT_W'(BEATS - 1));
  assign shifted = MSB_FIRST ? (sreg << SW) : (sreg >> SW);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      sreg  <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      sreg  <= sreg_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n  = state;
    sreg_n   = sreg;
    cnt_n    = cnt;
    in_ready = 1'b0;
    valid    = 1'b0;
    case (state)
      IDLE: begin
        in_ready = reset;
        if (in_valid) begin
          sreg_n  = in_word;
          cnt_n   = '0;
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        valid = 1'b1;
        if (ser_en) begin
          if (at_last) begin
            // Only an advancing last beat can take the next word, giving gapless streaming.
            in_ready = reset;
            cnt_n    = '0;
            if (in_valid) begin
              sreg_n = in_word;
            end else begin
              sreg_n  = shifted;
              state_n = IDLE;
            end
          end else begin
            cnt_n  = cnt + 1'b1;
            sreg_n = shifted;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign slice = MSB_FIRST ? sreg[W-1 -: SW] : sreg[SW-1:0];
  assign first = valid & (cnt == '0);
  assign last  = valid & at_last;
  assign count = cnt;
  assign busy  = (state == SHIFT);
endmodule

module ds_serializer #(
  parameter int ADDR_W    = 14,
  parameter int DATA_W    = 8,
  parameter int BEATS     = 4,
  parameter bit MSB_FIRST = 1'b1,
  localparam int AQ_W     = (ADDR_W + BEATS - 1) / BEATS,
  localparam int DQ_W     = (DATA_W + BEATS - 1) / BEATS,
  localparam int CNT_W    = $clog2(BEATS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ser_en,
  input  logic              gray_in_valid,
  output logic              gray_in_ready,
  input  logic [ADDR_W-1:0] gray_addr,
  output logic [AQ_W-1:0]   gray_addr_qtr,
  output logic              gray_valid,
  output logic              gray_first,
  output logic              gray_last,
  output logic [CNT_W-1:0]  gray_count,
  input  logic              lbp_in_valid,
  output logic              lbp_in_ready,
  input  logic [ADDR_W-1:0] lbp_addr,
  input  logic [DATA_W-1:0] lbp_data,
  output logic [AQ_W-1:0]   lbp_addr_qtr,
  output logic [DQ_W-1:0]   lbp_data_qtr,
  output logic              lbp_valid,
  output logic              lbp_first,
  output logic              lbp_last,
  output logic [CNT_W-1:0]  lbp_count,
  output logic [1:0]        dbg_state
);
  localparam int APW = BEATS * AQ_W;
  localparam int DPW = BEATS * DQ_W;
  localparam int LSW = AQ_W + DQ_W;

  logic [APW-1:0]       gray_pad, lbp_apad;
  logic [DPW-1:0]       lbp_dpad;
  logic [BEATS*LSW-1:0] lbp_word;
  logic [LSW-1:0]       lbp_slice;
  logic                 gray_busy, lbp_busy;

  assign gray_pad = APW'(gray_addr);
  assign lbp_apad = APW'(lbp_addr);
  assign lbp_dpad = DPW'(lbp_data);

  // Interleave so slice k of the lbp word carries address slice k beside data slice k.
  always_comb begin
    lbp_word = '0;
    for (int k = 0; k < BEATS; k++) begin
      lbp_word[k*LSW +: LSW] = {lbp_apad[k*AQ_W +: AQ_W], lbp_dpad[k*DQ_W +: DQ_W]};
    end
  end

  ds_ser_chan #(.BEATS(BEATS), .SW(AQ_W), .MSB_FIRST(MSB_FIRST)) u_gray (
    .clk(clk), .reset(reset), .ser_en(ser_en),
    .in_valid(gray_in_valid), .in_ready(gray_in_ready), .in_word(gray_pad),
    .slice(gray_addr_qtr), .valid(gray_valid), .first(gray_first), .last(gray_last),
    .count(gray_count), .busy(gray_busy)
  );

  ds_ser_chan #(.BEATS(BEATS), .SW(LSW), .MSB_FIRST(MSB_FIRST)) u_lbp (
    .clk(clk), .reset(reset), .ser_en(ser_en),
    .in_valid(lbp_in_valid), .in_ready(lbp_in_ready), .in_word(lbp_word),
    .slice(lbp_slice), .valid(lbp_valid), .first(lbp_first), .last(lbp_last),
    .count(lbp_count), .busy(lbp_busy)
  );

  assign lbp_addr_qtr = lbp_slice[LSW-1:DQ_W];
  assign lbp_data_qtr = lbp_slice[DQ_W-1:0];
  assign dbg_state    = {lbp_busy, gray_busy};
endmodule

// File: tb/tb_ds_serializer.sv
// Bench for ds_serializer: default, LSB-first and 16/12/3 instances with a queue scoreboard
// checked by a negedge monitor on every advancing beat.

module tb_ds_serializer;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, ser_en;
  logic gray_in_valid, lbp_in_valid;
  logic [13:0] gray_addr, lbp_addr;
  logic [7:0]  lbp_data;

  logic d_g_rdy, d_g_v, d_g_f, d_g_l, d_l_rdy, d_l_v, d_l_f, d_l_l;
  logic [3:0] d_g_aq, d_l_aq;
  logic [1:0] d_l_dq, d_g_c, d_l_c, d_dbg;
  logic l_g_rdy, l_g_v, l_g_f, l_g_l, l_l_rdy, l_l_v, l_l_f, l_l_l;
  logic [3:0] l_g_aq, l_l_aq;
  logic [1:0] l_l_dq, l_g_c, l_l_c, l_dbg;

  logic b_g_in_valid, b_l_in_valid;
  logic [15:0] b_g_addr, b_l_addr;
  logic [11:0] b_l_data;
  logic b_g_rdy, b_g_v, b_g_f, b_g_l, b_l_rdy, b_l_v, b_l_f, b_l_l;
  logic [5:0] b_g_aq, b_l_aq;
  logic [3:0] b_l_dq;
  logic [1:0] b_g_c, b_l_c, b_dbg;

  ds_serializer u_def (
    .clk(clk), .reset(reset), .ser_en(ser_en),
    .gray_in_valid(gray_in_valid), .gray_in_ready(d_g_rdy), .gray_addr(gray_addr),
    .gray_addr_qtr(d_g_aq), .gray_valid(d_g_v), .gray_first(d_g_f), .gray_last(d_g_l),
    .gray_count(d_g_c),
    .lbp_in_valid(lbp_in_valid), .lbp_in_ready(d_l_rdy), .lbp_addr(lbp_addr), .lbp_data(lbp_data),
    .lbp_addr_qtr(d_l_aq), .lbp_data_qtr(d_l_dq), .lbp_valid(d_l_v), .lbp_first(d_l_f),
    .lbp_last(d_l_l), .lbp_count(d_l_c), .dbg_state(d_dbg)
  );

  ds_serializer #(.MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .reset(reset), .ser_en(ser_en),
    .gray_in_valid(gray_in_valid), .gray_in_ready(l_g_rdy), .gray_addr(gray_addr),
    .gray_addr_qtr(l_g_aq), .gray_valid(l_g_v), .gray_first(l_g_f), .gray_last(l_g_l),
    .gray_count(l_g_c),
    .lbp_in_valid(lbp_in_valid), .lbp_in_ready(l_l_rdy), .lbp_addr(lbp_addr), .lbp_data(lbp_data),
    .lbp_addr_qtr(l_l_aq), .lbp_data_qtr(l_l_dq), .lbp_valid(l_l_v), .lbp_first(l_l_f),
    .lbp_last(l_l_l), .lbp_count(l_l_c), .dbg_state(l_dbg)
  );

  ds_serializer #(.ADDR_W(16), .DATA_W(12), .BEATS(3)) u_big (
    .clk(clk), .reset(reset), .ser_en(ser_en),
    .gray_in_valid(b_g_in_valid), .gray_in_ready(b_g_rdy), .gray_addr(b_g_addr),
    .gray_addr_qtr(b_g_aq), .gray_valid(b_g_v), .gray_first(b_g_f), .gray_last(b_g_l),
    .gray_count(b_g_c),
    .lbp_in_valid(b_l_in_valid), .lbp_in_ready(b_l_rdy), .lbp_addr(b_l_addr), .lbp_data(b_l_data),
    .lbp_addr_qtr(b_l_aq), .lbp_data_qtr(b_l_dq), .lbp_valid(b_l_v), .lbp_first(b_l_f),
    .lbp_last(b_l_l), .lbp_count(b_l_c), .dbg_state(b_dbg)
  );

  // Channels: 0 def gray, 1 def lbp, 2 lsb gray, 3 lsb lbp, 4 big gray, 5 big lbp.
  logic [31:0] exp_q[6][$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int gbeat_cyc[$];
  bit rnd_done;

  always @(posedge clk) cyc++;

  function automatic logic [31:0] pk(input logic r, input logic f, input logic l,
                                     input logic [3:0] c, input logic [7:0] a, input logic [7:0] d);
    return {9'b0, r, f, l, c, a, d};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic mon(input int ch, input logic v, input logic [31:0] act);
    logic [31:0] e;
    if (v !== 1'b1) return;
    checks++;
    if (exp_q[ch].size() == 0) begin
      errors++;
      $display("FAIL beat_ch%0d: got unexpected beat %h, required none", ch, act);
    end else begin
      e = exp_q[ch].pop_front();
      if (act !== e) begin
        errors++;
        $display("FAIL beat_ch%0d: got %h, required %h", ch, act, e);
      end
    end
  endtask

  // Monitor: a beat is consumed on an edge where it is valid and ser_en is high.
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      mon(0, d_g_v & ser_en, pk(d_g_rdy, d_g_f, d_g_l, 4'(d_g_c), 8'(d_g_aq), 8'h0));
      mon(1, d_l_v & ser_en, pk(d_l_rdy, d_l_f, d_l_l, 4'(d_l_c), 8'(d_l_aq), 8'(d_l_dq)));
      mon(2, l_g_v & ser_en, pk(l_g_rdy, l_g_f, l_g_l, 4'(l_g_c), 8'(l_g_aq), 8'h0));
      mon(3, l_l_v & ser_en, pk(l_l_rdy, l_l_f, l_l_l, 4'(l_l_c), 8'(l_l_aq), 8'(l_l_dq)));
      mon(4, b_g_v & ser_en, pk(b_g_rdy, b_g_f, b_g_l, 4'(b_g_c), 8'(b_g_aq), 8'h0));
      mon(5, b_l_v & ser_en, pk(b_l_rdy, b_l_f, b_l_l, 4'(b_l_c), 8'(b_l_aq), 8'(b_l_dq)));
      if (d_g_v && ser_en) gbeat_cyc.push_back(cyc);
    end
  end

  // Hand-written beat sequences: aseq nibbles and dseq bit-pairs listed in beat order.
  task automatic push4(input int ch, input logic [15:0] aseq, input logic [7:0] dseq);
    for (int k = 0; k < 4; k++)
      exp_q[ch].push_back(pk(k == 3, k == 0, k == 3, 4'(k),
                             8'(aseq[15-4*k -: 4]), 8'(dseq[7-2*k -: 2])));
  endtask

  function automatic logic [31:0] bmodel(input logic [15:0] a, input logic [11:0] d,
                                         input bit is_lbp, input int k);
    logic [17:0] ap;
    int slot;
    ap = {2'b00, a};
    slot = 2 - k;
    return pk(k == 2, k == 0, k == 2, 4'(k), 8'(ap[slot*6 +: 6]),
              is_lbp ? 8'(d[slot*4 +: 4]) : 8'h0);
  endfunction

  function automatic logic rdy_of(input int w);
    case (w)
      0: return d_g_rdy;
      1: return d_l_rdy;
      4: return b_g_rdy;
      default: return b_l_rdy;
    endcase
  endfunction

  task automatic wait_ready(input int w);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (rdy_of(w) !== 1'b1 && n < 100);
    if (rdy_of(w) !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL accept_ch%0d: got ready=0 after 100 cycles, required 1", w);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_gray(input logic [13:0] a, input logic [15:0] d_seq, input logic [15:0] l_seq);
    push4(0, d_seq, 8'h00);
    push4(2, l_seq, 8'h00);
    gray_addr = a;
    gray_in_valid = 1'b1;
    wait_ready(0);
    gray_in_valid = 1'b0;
  endtask

  task automatic send_lbp(input logic [13:0] a, input logic [7:0] d,
                          input logic [15:0] da, input logic [7:0] dd,
                          input logic [15:0] la, input logic [7:0] ld);
    push4(1, da, dd);
    push4(3, la, ld);
    lbp_addr = a;
    lbp_data = d;
    lbp_in_valid = 1'b1;
    wait_ready(1);
    lbp_in_valid = 1'b0;
  endtask

  task automatic send_bgray(input logic [15:0] a);
    for (int k = 0; k < 3; k++) exp_q[4].push_back(bmodel(a, 12'h0, 1'b0, k));
    b_g_addr = a;
    b_g_in_valid = 1'b1;
    wait_ready(4);
    b_g_in_valid = 1'b0;
  endtask

  task automatic send_blbp(input logic [15:0] a, input logic [11:0] d);
    for (int k = 0; k < 3; k++) exp_q[5].push_back(bmodel(a, d, 1'b1, k));
    b_l_addr = a;
    b_l_data = d;
    b_l_in_valid = 1'b1;
    wait_ready(5);
    b_l_in_valid = 1'b0;
  endtask

  function automatic int pending();
    int s;
    s = 0;
    for (int i = 0; i < 6; i++) s += exp_q[i].size();
    return s;
  endfunction

  task automatic drain(input string name);
    int n;
    n = 0;
    while (pending() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_drain"}, 32'(pending()), 32'd0);
    @(negedge clk);
    chk({name, "_idle"}, {d_g_v, d_l_v, d_g_aq, d_l_aq, d_l_dq, d_g_rdy, d_l_rdy},
        {1'b0, 1'b0, 4'h0, 4'h0, 2'b00, 1'b1, 1'b1});
    @(posedge clk);
    #1;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: got no finish by 50000ns, required finish");
    $fatal(1);
  end

  initial begin
    int span;
    reset = 1'b0; ser_en = 1'b1;
    gray_in_valid = 1'b0; lbp_in_valid = 1'b0; gray_addr = '0; lbp_addr = '0; lbp_data = '0;
    b_g_in_valid = 1'b0; b_l_in_valid = 1'b0; b_g_addr = '0; b_l_addr = '0; b_l_data = '0;
    rnd_done = 1'b0;
    #3;
    chk("reset_def", {d_g_rdy, d_g_v, d_g_f, d_g_l, d_g_c, d_g_aq, d_l_rdy, d_l_v, d_l_c, d_l_aq, d_l_dq, d_dbg}, 32'h0);
    chk("reset_big", {b_g_rdy, b_g_v, b_g_aq, b_l_rdy, b_l_v, b_l_aq, b_l_dq, b_dbg}, 32'h0);
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", {d_g_rdy, d_l_rdy, l_g_rdy, b_g_rdy, b_l_rdy}, 5'b11111);
    @(posedge clk); #1;

    // Gray 0x2ABC; LSB-first instance sees the reversed order.
    send_gray(14'h2ABC, 16'h2ABC, 16'hCBA2);
    chk("gray_busy_dbg", {30'h0, d_dbg}, 32'h1);
    drain("t1");

    // Lbp 0x1234 / 0xB4: data pairs 10,11,01,00 (MSB first) and 00,01,11,10 (LSB first).
    send_lbp(14'h1234, 8'hB4, 16'h1234, 8'b10_11_01_00, 16'h4321, 8'b00_01_11_10);
    drain("t2");

    // Back-to-back gray words with valid held: 8 beats on consecutive cycles.
    gbeat_cyc.delete();
    send_gray(14'h0001, 16'h0001, 16'h1000);
    send_gray(14'h3FFF, 16'h3FFF, 16'hFFF3);
    drain("t4");
    span = (gbeat_cyc.size() == 8) ? gbeat_cyc[7] - gbeat_cyc[0] : -1;
    chk("b2b_beats", 32'(gbeat_cyc.size()), 32'd8);
    chk("b2b_span", 32'(span), 32'd7);

    // ser_en low for 3 cycles on beat 1 of the lbp word.
    send_lbp(14'h1234, 8'hB4, 16'h1234, 8'b10_11_01_00, 16'h4321, 8'b00_01_11_10);
    @(posedge clk); #1;
    ser_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("freeze_lbp", {d_l_v, d_l_f, d_l_l, d_l_c, d_l_aq, d_l_dq, d_l_rdy},
          {1'b1, 1'b0, 1'b0, 2'd1, 4'h2, 2'b11, 1'b0});
      chk("freeze_gray", {d_g_v, d_g_rdy}, 2'b01);
      @(posedge clk); #1;
    end
    ser_en = 1'b1;
    drain("t5");

    // Reset on beat 2 drops the word; the next word starts cleanly at beat 0.
    send_gray(14'h2ABC, 16'h2ABC, 16'hCBA2);
    @(posedge clk); #1;
    @(posedge clk); #1;
    #2 reset = 1'b0;
    #1;
    chk("midword_reset", {d_g_v, d_g_f, d_g_l, d_g_c, d_g_aq, d_g_rdy, d_dbg, l_g_v, l_g_aq, l_g_c}, 32'h0);
    for (int i = 0; i < 6; i++) exp_q[i].delete();
    @(posedge clk); #1 reset = 1'b1;
    send_gray(14'h1234, 16'h1234, 16'h4321);
    drain("t6");

    // 16/12/3 instance: random words on both channels with random ser_en stalls.
    fork
      begin
        fork
          for (int i = 0; i < 8; i++) send_bgray(16'($urandom_range(0, 65535)));
          for (int i = 0; i < 8; i++) send_blbp(16'($urandom_range(0, 65535)), 12'($urandom_range(0, 4095)));
        join
        rnd_done = 1'b1;
      end
      while (!rnd_done) begin
        ser_en = ($urandom_range(0, 3) != 0);
        @(posedge clk); #1;
      end
    join
    ser_en = 1'b1;
    drain("rand");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
